// File: rtl/mod_inverse_bin.sv
// Modular inverse a^-1 mod m (odd m) by the binary extended Euclidean algorithm,
// one shift/subtract decision per clock, AXI-stream handshakes on both sides.
module mod_inverse_bin #(
  parameter int SIZE = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] input_base_tdata,
  input  logic            input_base_tvalid,
  output logic            input_base_tready,
  input  logic [SIZE-1:0] input_modulus_tdata,
  input  logic            input_modulus_tvalid,
  output logic            input_modulus_tready,
  output logic [SIZE-1:0] output_tdata,
  output logic            output_tuser,
  output logic            output_tvalid,
  input  logic            output_tready
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RUN, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [SIZE-1:0] r_a, r_m, r_u, r_v, r_x1, r_x2;
  logic [SIZE-1:0] r_out_data;
  logic            r_out_user;
  logic            w_accept;
  logic            w_illegal;
  logic            w_run_term;
  logic            w_load;
  logic [SIZE-1:0] w_res_data;
  logic            w_res_err;

  // Halving mod m: an odd x is made even by adding m, using one extra bit so the carry survives.
  function automatic logic [SIZE-1:0] half_mod(input logic [SIZE-1:0] x, input logic [SIZE-1:0] m);
    logic [SIZE:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
    return s[SIZE:1];
  endfunction

  // Both operands lie in [0, m), so the wrapped x - y + m is exact in SIZE bits.
  function automatic logic [SIZE-1:0] sub_mod(input logic [SIZE-1:0] x, input logic [SIZE-1:0] y,
                                              input logic [SIZE-1:0] m);
    return (x >= y) ? (x - y) : (x - y + m);
  endfunction

  assign w_accept   = (r_state == S_IDLE) && input_base_tvalid && input_modulus_tvalid;
  assign w_illegal  = !r_m[0] || (r_m < SIZE'(3)) || (r_a == '0) || (r_a >= r_m);
  assign w_run_term = (r_u == SIZE'(1)) || (r_v == SIZE'(1)) || (r_u == '0) || (r_v == '0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_res_data   = '0;
    w_res_err    = 1'b0;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_CHECK;
      S_CHECK: begin
        if (w_illegal) begin
          w_state_next = S_DONE;
          w_load       = 1'b1;
          w_res_err    = 1'b1;
        end else begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_run_term) begin
          w_state_next = S_DONE;
          w_load       = 1'b1;
          if (r_u == SIZE'(1))      w_res_data = r_x1;
          else if (r_v == SIZE'(1)) w_res_data = r_x2;
          else                      w_res_err  = 1'b1;
        end
      end
      S_DONE:  if (output_tready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Working registers carry no reset; CHECK re-initialises them for every operation.
  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          r_a <= input_base_tdata;
          r_m <= input_modulus_tdata;
        end
      end
      S_CHECK: begin
        r_u  <= r_a;
        r_v  <= r_m;
        r_x1 <= SIZE'(1);
        r_x2 <= '0;
      end
      S_RUN: begin
        if (!w_run_term) begin
          if (!r_u[0]) begin
            r_u  <= r_u >> 1;
            r_x1 <= half_mod(r_x1, r_m);
          end else if (!r_v[0]) begin
            r_v  <= r_v >> 1;
            r_x2 <= half_mod(r_x2, r_m);
          end else if (r_u >= r_v) begin
            r_u  <= r_u - r_v;
            r_x1 <= sub_mod(r_x1, r_x2, r_m);
          end else begin
            r_v  <= r_v - r_u;
            r_x2 <= sub_mod(r_x2, r_x1, r_m);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data <= '0;
      r_out_user <= 1'b0;
    end else if (w_load) begin
      r_out_data <= w_res_data;
      r_out_user <= w_res_err;
    end
  end

  assign input_base_tready    = (r_state == S_IDLE);
  assign input_modulus_tready = (r_state == S_IDLE);
  assign output_tvalid        = (r_state == S_DONE);
  assign output_tdata         = r_out_data;
  assign output_tuser         = r_out_user;

endmodule

// File: tb/tb_mod_inverse_bin.sv
// Randomised and directed bench for mod_inverse_bin, checked against a
// division-based extended-Euclid reference model.
module tb_mod_inverse_bin;
  localparam int SIZE = 64;
  localparam int LAT_MAX = 4 * SIZE + 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [SIZE-1:0] base_tdata = '0;
  logic            base_tvalid = 1'b0;
  logic            base_tready;
  logic [SIZE-1:0] mod_tdata = '0;
  logic            mod_tvalid = 1'b0;
  logic            mod_tready;
  logic [SIZE-1:0] out_tdata;
  logic            out_tuser;
  logic            out_tvalid;
  logic            out_tready = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  mod_inverse_bin #(.SIZE(SIZE)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .input_base_tdata    (base_tdata),
    .input_base_tvalid   (base_tvalid),
    .input_base_tready   (base_tready),
    .input_modulus_tdata (mod_tdata),
    .input_modulus_tvalid(mod_tvalid),
    .input_modulus_tready(mod_tready),
    .output_tdata        (out_tdata),
    .output_tuser        (out_tuser),
    .output_tvalid       (out_tvalid),
    .output_tready       (out_tready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: classic extended Euclid with division, plus the legality rules.
  task automatic ref_inv(input logic [SIZE-1:0] a, input logic [SIZE-1:0] m,
                         output logic [SIZE-1:0] r, output bit err);
    logic [SIZE-1:0] r0, r1, q, tmp;
    logic signed [129:0] t0, t1, tt;
    r = '0;
    err = 1'b0;
    if (!m[0] || m < 3 || a == 0 || a >= m) begin
      err = 1'b1;
      return;
    end
    r0 = m; r1 = a; t0 = 0; t1 = 1;
    while (r1 != 0) begin
      q   = r0 / r1;
      tmp = r0 - q * r1;
      r0  = r1;
      r1  = tmp;
      tt  = t0 - $signed({66'b0, q}) * t1;
      t0  = t1;
      t1  = tt;
    end
    if (r0 != 1) begin
      err = 1'b1;
    end else begin
      if (t0 < 0) t0 = t0 + $signed({66'b0, m});
      r = t0[SIZE-1:0];
    end
  endtask

  // Offers a pair at a negedge and returns just after the accepting posedge.
  task automatic send(input logic [SIZE-1:0] a, input logic [SIZE-1:0] m);
    int waits;
    @(negedge clk);
    base_tdata = a; mod_tdata = m;
    base_tvalid = 1'b1; mod_tvalid = 1'b1;
    waits = 0;
    while (!(base_tready && mod_tready) && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 50) chk("accept_timeout", 1, 0);
    @(posedge clk);
    #1;
    base_tvalid = 1'b0; mod_tvalid = 1'b0;
  endtask

  // lat = cycles from the accept cycle T until tvalid is seen (tvalid at T+lat).
  task automatic wait_out(output logic [SIZE-1:0] data, output bit user, output int lat);
    lat = 1;
    data = '0;
    user = 1'b0;
    @(negedge clk);
    while (!out_tvalid && lat <= LAT_MAX + 5) begin
      @(negedge clk);
      lat++;
    end
    if (!out_tvalid) chk("result_timeout", 1, 0);
    data = out_tdata;
    user = out_tuser;
  endtask

  initial begin
    logic [SIZE-1:0] d, a, m, exp_d;
    bit              u, exp_u;
    int              lat, w;
    logic [127:0]    prod;

    repeat (3) @(negedge clk);
    chk("rst_base_tready", base_tready, 1);
    chk("rst_mod_tready",  mod_tready, 1);
    chk("rst_tvalid",      out_tvalid, 0);
    chk("rst_tdata",       out_tdata, 0);
    chk("rst_tuser",       out_tuser, 0);
    rst = 1'b0;

    send(3, 7);  wait_out(d, u, lat);
    chk("basic_data", d, 5); chk("basic_user", u, 0); chk("basic_lat", lat, 6);

    send(1, 11); wait_out(d, u, lat);
    chk("triv_data", d, 1); chk("triv_user", u, 0); chk("triv_lat", lat, 3);

    send(6, 9);  wait_out(d, u, lat);
    chk("gcd_user", u, 1); chk("gcd_data", d, 0);
    send(4, 10); wait_out(d, u, lat);
    chk("even_user", u, 1); chk("even_data", d, 0); chk("even_lat", lat, 2);
    send(9, 7);  wait_out(d, u, lat);
    chk("ageqm_user", u, 1); chk("ageqm_data", d, 0); chk("ageqm_lat", lat, 2);

    // A lone base valid must not be consumed.
    @(negedge clk);
    base_tdata = 5; mod_tdata = 7; base_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("lone_tready", base_tready, 1);
      chk("lone_tvalid", out_tvalid, 0);
    end
    base_tvalid = 1'b0;

    out_tready = 1'b0;
    send(2, 11); wait_out(d, u, lat);
    chk("hs_data", d, 6); chk("hs_user", u, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_tvalid", out_tvalid, 1);
      chk("bp_tdata",  out_tdata, 6);
      chk("bp_tready", base_tready | mod_tready, 0);
    end
    out_tready = 1'b1;
    @(negedge clk);
    chk("post_hs_tvalid", out_tvalid, 0);
    chk("post_hs_tready", base_tready & mod_tready, 1);

    m = (64'h1 << 61) - 1;
    send(2, m); wait_out(d, u, lat);
    chk("wide_data", d, 64'h1 << 60); chk("wide_user", u, 0);
    chk("wide_lat_ok", lat <= SIZE * 4 + 3, 1);

    // Reset while the engine is in RUN.
    send(3, 7);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_run_tready", base_tready & mod_tready, 1);
    chk("rst_run_tvalid", out_tvalid, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rst_run_quiet", out_tvalid, 0);
    end
    send(5, 7); wait_out(d, u, lat);
    chk("after_rst_data", d, 3); chk("after_rst_user", u, 0);

    for (int i = 0; i < 40; i++) begin
      w = $urandom_range(4, SIZE);
      m = {$urandom, $urandom};
      if (w < SIZE) m = m & ((64'h1 << w) - 1);
      if ($urandom_range(0, 9) != 0) m[0] = 1'b1;
      a = (m == 0) ? {$urandom, $urandom} : {$urandom, $urandom} % m;
      if ($urandom_range(0, 19) == 0) a = m;
      if ($urandom_range(0, 19) == 0) a = 0;
      ref_inv(a, m, exp_d, exp_u);
      send(a, m); wait_out(d, u, lat);
      chk("rnd_user", u, exp_u);
      chk("rnd_data", d, exp_d);
      chk("rnd_lat_bound", lat <= LAT_MAX, 1);
      if (!exp_u) begin
        prod = {64'b0, a} * {64'b0, d};
        chk("rnd_inverse", prod % {64'b0, m}, 1);
      end
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/mod_inverse_bin.md
# mod_inverse_bin

Parametrised modular-inverse engine for the ElGamal datapath. It computes a⁻¹ mod m for odd modulus m using the binary extended Euclidean algorithm, one shift/subtract step per clock, with no divider or multiplier instances. It has full AXI-stream handshakes on inputs and output, reports non-invertible operands in-band, and accepts a new operand pair directly after each result is consumed. It sits between key/ciphertext preparation and the modular-exponentiation stage, which needs a⁻¹ during decryption.

## Interface
Parameters:
- SIZE, 64, operand/result width in bits (≥ 4)

Ports:
- clk  input  1  clock; single clock domain
- rst  input  1  reset; synchronous, active-high
- input_base_tdata  input  SIZE  operand a
- input_base_tvalid  input  1  a valid
- input_base_tready  output  1  a accepted
- input_modulus_tdata  input  SIZE  modulus m
- input_modulus_tvalid  input  1  m valid
- input_modulus_tready  output  1  m accepted
- output_tdata  output  SIZE  a⁻¹ mod m, or 0 on error
- output_tuser  output  1  1 = not invertible / illegal operands
- output_tvalid  output  1  result valid
- output_tready  input  1  downstream accepts result

## Operation
- State machine: IDLE → CHECK → RUN → DONE → IDLE.
- IDLE
  - Both input treadys are high.
  - Accept only jointly: when both tvalids are high, latch a and m and go to CHECK. A single valid input is not consumed.
- CHECK (1 cycle)
  - Error if m even, m < 3, a == 0, or a ≥ m. On error go to DONE with tdata = 0, tuser = 1.
  - Otherwise init u = a, v = m, x1 = 1, x2 = 0, and go to RUN.
- RUN, one decision per cycle, in priority order:
  1. u == 1 → result x1; go to DONE.
  2. v == 1 → result x2; go to DONE.
  3. u == 0 or v == 0 → error; go to DONE.
  4. u even → u >>= 1; x1 = x1 even ? x1>>1 : (x1+m)>>1.
  5. v even → v >>= 1; same rule applied to x2.
  6. u ≥ v → u -= v; x1 = (x1 − x2) mod m.
  7. otherwise → v -= u; x2 = (x2 − x1) mod m.
- Arithmetic rules:
  - x1 + m is formed in SIZE+1 bits, so no overflow is lost before the shift.
  - Modular subtraction: if x ≥ y the result is x − y, else x − y + m.
  - x1 and x2 always stay in [0, m).
- DONE
  - output_tvalid is high; tdata and tuser are held stable until output_tready.
  - On the handshake, go to IDLE.
  - Input treadys are low in CHECK, RUN and DONE.
- Step bound: each subtract step is always followed by a halving, so update steps N ≤ 4·SIZE.
- Reset in any state:
  - Returns to IDLE on the next edge.
  - Any in-flight computation is discarded; no result is emitted.

## Timing
- Reset values:
  - input_base_tready = input_modulus_tready = 1 (IDLE).
  - output_tvalid = 0, output_tdata = 0, output_tuser = 0.
- Accept on cycle T (both valid and both ready high). CHECK runs on T+1; RUN starts on T+2.
- Latency to output_tvalid:
  - Success: T+3+N, where N = number of RUN update steps.
  - CHECK error: T+2.
  - RUN error: T+3+N.
- Backpressure: while output_tready is low, output_tvalid stays high and data is unchanged.
- After the output handshake on cycle D, IDLE is entered on D+1, and a new pair can be accepted on D+1.
- Sustained throughput: one operation per (latency + 1) cycles when output_tready is held high.

## Test plan
- Basic case: a = 3, m = 7, output_tready = 1.
  - Required: tdata = 5, tuser = 0, tvalid at T+6 (N = 3).
- Trivial operand: a = 1, m = 11.
  - Required: tdata = 1, tuser = 0, tvalid exactly at T+3.
- Error paths, three back-to-back ops:
  - a = 6, m = 9 → tuser = 1, tdata = 0 (gcd = 3, detected in RUN).
  - a = 4, m = 10 → tuser = 1 at T+2 (even modulus).
  - a = 9, m = 7 → tuser = 1 (a ≥ m).
- Handshake:
  - Only base_tvalid high for 4 cycles → nothing accepted, no output.
  - Then both valid: a = 2, m = 11 → tdata = 6.
  - Hold output_tready low 5 cycles → tvalid and data stable, input treadys low.
  - Release → handshake, IDLE next cycle.
- Wide case, SIZE = 64: a = 2, m = 2⁶¹ − 1.
  - Required: tdata = 2⁶⁰, tuser = 0, tvalid within T+3+256.
  - Random sweep: check a·result mod m == 1 against a reference model.
- Reset mid-RUN: assert rst during RUN of a = 3, m = 7.
  - Required: no tvalid; treadys = 1 the cycle after reset.
  - Next op a = 5, m = 7 → tdata = 3.
